// File: rtl/controle_de_tentativas_if.sv
// Bus between the attempt controller and its neighbours.
// Inputs come from the code comparator and user buttons; outputs drive the
// lock actuator and status LEDs. The slave modport is the controller side.
interface controle_de_tentativas_if #(
  parameter int MAX_TRIES = 3
);
  localparam int AW = $clog2(MAX_TRIES + 1);

  logic          confirm;
  logic          match;
  logic          cancel;
  logic          unlocked;
  logic          error_pulse;
  logic          locked_out;
  logic [AW-1:0] attempts_left;

  modport master (
    output confirm,
    output match,
    output cancel,
    input  unlocked,
    input  error_pulse,
    input  locked_out,
    input  attempts_left
  );

  modport slave (
    input  confirm,
    input  match,
    input  cancel,
    output unlocked,
    output error_pulse,
    output locked_out,
    output attempts_left
  );
endinterface

// File: rtl/controle_de_tentativas.sv
// Access-attempt controller sitting after the 3-bit code comparator.
// A rising edge of confirm is one attempt; match decides success. A correct
// code opens the lock for OPEN_CYCLES cycles (cancel closes it early). After
// MAX_TRIES consecutive failures the controller locks out for LOCK_CYCLES.
// Optional macro CONFIRM_SYNC_EN: confirm goes through a 2-flop synchronizer
// (both flops reset to 1) before edge detection, adding 2 cycles of latency.
module controle_de_tentativas #(
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYCLES = 20,
  parameter int LOCK_CYCLES = 50
) (
  input  logic                    clk,
  input  logic                    reset,
  controle_de_tentativas_if.slave bus
);

  localparam int AW      = $clog2(MAX_TRIES + 1);
  localparam int MAX_CYC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 1);
  localparam logic [AW-1:0] TRIES_FULL = AW'(MAX_TRIES);
  localparam logic [AW-1:0] TRIES_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [AW-1:0] attempts_q, attempts_d;
  logic          unlocked_q, unlocked_d;
  logic          error_q, error_d;
  logic          locked_q, locked_d;

  logic          confirm_s;
  logic          confirm_q;
  logic          attempt;

`ifdef CONFIRM_SYNC_EN
  logic sync1_q;
  logic sync2_q;

  // Two-flop synchronizer for the asynchronous push-button; reset high so a
  // button held through reset never looks like a fresh press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.confirm;
      sync2_q <= sync1_q;
    end
  end

  assign confirm_s = sync2_q;
`else
  assign confirm_s = bus.confirm;
`endif

  // Edge-detect history; reset to 1 so a held button is not an attempt.
  always_ff @(posedge clk) begin
    if (reset) begin
      confirm_q <= 1'b1;
    end else begin
      confirm_q <= confirm_s;
    end
  end

  assign attempt = confirm_s & ~confirm_q;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      attempts_q <= TRIES_FULL;
      unlocked_q <= 1'b0;
      error_q    <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      attempts_q <= attempts_d;
      unlocked_q <= unlocked_d;
      error_q    <= error_d;
      locked_q   <= locked_d;
    end
  end

  // Next-state and next-output decision; outputs change on the attempt edge.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    attempts_d = attempts_q;
    unlocked_d = unlocked_q;
    locked_d   = locked_q;
    error_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (attempt) begin
          if (bus.match) begin
            state_d    = OPEN;
            unlocked_d = 1'b1;
            timer_d    = OPEN_LOAD;
            attempts_d = TRIES_FULL;
          end else if (attempts_q > TRIES_ONE) begin
            attempts_d = attempts_q - TRIES_ONE;
            error_d    = 1'b1;
          end else begin
            // Last try spent: flag the error and lock out on the same edge.
            state_d    = LOCKOUT;
            error_d    = 1'b1;
            attempts_d = '0;
            locked_d   = 1'b1;
            timer_d    = LOCK_LOAD;
          end
        end
      end

      OPEN: begin
        // Attempts are ignored while open; cancel beats the running timer.
        if (bus.cancel || (timer_q == '0)) begin
          state_d    = IDLE;
          unlocked_d = 1'b0;
          timer_d    = '0;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      LOCKOUT: begin
        // Attempts and cancel are both ignored until the timer runs out.
        if (timer_q == '0) begin
          state_d    = IDLE;
          locked_d   = 1'b0;
          attempts_d = TRIES_FULL;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        timer_d    = '0;
        attempts_d = TRIES_FULL;
        unlocked_d = 1'b0;
        locked_d   = 1'b0;
      end
    endcase
  end

  assign bus.unlocked      = unlocked_q;
  assign bus.error_pulse   = error_q;
  assign bus.locked_out    = locked_q;
  assign bus.attempts_left = attempts_q;

  // Output invariants: single-cycle error pulse, never open and locked out.
  a_error_single : assert property (@(posedge clk) disable iff (reset)
    error_q |=> !error_q);
  a_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(unlocked_q && locked_q));

endmodule

// File: tb/tb_controle_de_tentativas.sv
// Bench for controle_de_tentativas with MAX_TRIES=3, OPEN_CYCLES=4,
// LOCK_CYCLES=8. A vector table drives one cycle per row; expected outputs
// go into a scoreboard queue when a row is driven and are popped after the
// clock edge. Hand-written sequences measure latency and held durations.
module tb_controle_de_tentativas;

  localparam int MAX_TRIES   = 3;
  localparam int OPEN_CYCLES = 4;
  localparam int LOCK_CYCLES = 8;
`ifdef CONFIRM_SYNC_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  logic clk;
  logic reset;

  controle_de_tentativas_if #(.MAX_TRIES(MAX_TRIES)) bus ();

  controle_de_tentativas #(
    .MAX_TRIES  (MAX_TRIES),
    .OPEN_CYCLES(OPEN_CYCLES),
    .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r, c, m, x;
    logic       eu, ee, el;
    logic [1:0] ea;
  } vec_t;

  typedef struct {
    logic       eu, ee, el;
    logic [1:0] ea;
    int         idx;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, c, m, x, eu, ee, el, input logic [1:0] ea);
    vec_t v;
    v.r = r; v.c = c; v.m = m; v.x = x;
    v.eu = eu; v.ee = ee; v.el = el; v.ea = ea;
    tbl.push_back(v);
  endtask

  // Continuous invariant monitors.
  logic prev_err = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      if (bus.error_pulse) chk("err_single", 0, int'(prev_err), 0);
      if (bus.unlocked)    chk("exclusive", 0, int'(bus.locked_out), 0);
    end
    prev_err = bus.error_pulse;
  end

  initial begin
    int lat;
    int dur;
    bit seen;
    bit bad;
    exp_t e;

    reset       = 1'b1;
    bus.confirm = 1'b1;
    bus.match   = 1'b0;
    bus.cancel  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_unlocked", 0, int'(bus.unlocked), 0);
    chk("rst_err", 0, int'(bus.error_pulse), 0);
    chk("rst_locked", 0, int'(bus.locked_out), 0);
    chk("rst_left", 0, int'(bus.attempts_left), 3);

`ifndef CONFIRM_SYNC_EN
    // r  c  m  x   eu ee el ea
    // confirm held through and after reset
    add(1, 1, 0, 0, 0, 0, 0, 3);
    add(1, 1, 0, 0, 0, 0, 0, 3);
    add(0, 1, 0, 0, 0, 0, 0, 3);
    add(0, 1, 1, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 3);
    // correct code: open for 4 cycles
    add(0, 1, 1, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 3);
    // two failures, then success restores the counter
    add(0, 1, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 1, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 3);
    add(0, 1, 0, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 3);
    // three failures -> lockout for 8 cycles, attempts and cancel ignored
    add(0, 1, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    // attempt on the expiry edge is dropped; holding it gives no new edge
    add(0, 1, 1, 0, 0, 0, 0, 3);
    add(0, 1, 1, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 3);
    // cancel in second open cycle; cancel in idle does nothing
    add(0, 1, 1, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 3);
    add(0, 0, 0, 1, 0, 0, 0, 3);
    add(0, 0, 0, 1, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 3);
    // reset in the middle of lockout
    add(0, 1, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(1, 0, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 3);
    add(0, 1, 0, 0, 0, 1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 2);
    // reset while open
    add(0, 1, 1, 0, 1, 0, 0, 3);
    add(1, 0, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 3);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset       = tbl[i].r;
      bus.confirm = tbl[i].c;
      bus.match   = tbl[i].m;
      bus.cancel  = tbl[i].x;
      e.eu = tbl[i].eu; e.ee = tbl[i].ee; e.el = tbl[i].el;
      e.ea = tbl[i].ea; e.idx = i;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        chk("sb_empty", i, 1, 0);
      end else begin
        e = sb.pop_front();
        chk("unlocked", e.idx, int'(bus.unlocked), int'(e.eu));
        chk("error_pulse", e.idx, int'(bus.error_pulse), int'(e.ee));
        chk("locked_out", e.idx, int'(bus.locked_out), int'(e.el));
        chk("attempts_left", e.idx, int'(bus.attempts_left), int'(e.ea));
      end
    end
`endif

    // Clean start for the hand-written sequences.
    @(negedge clk);
    reset = 1'b1; bus.confirm = 1'b0; bus.match = 1'b0; bus.cancel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Latency from raw confirm edge to unlocked, then open duration.
    bus.match = 1'b1; bus.confirm = 1'b1;
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.unlocked) seen = 1'b1;
    end
    chk("unlock_seen", 0, int'(seen), 1);
    chk("unlock_latency", 0, lat, EXP_LAT);
    dur = 0;
    while (bus.unlocked && dur < 50) begin
      dur++;
      @(posedge clk); #1;
    end
    chk("open_duration", 0, dur, OPEN_CYCLES);
    chk("open_left", 0, int'(bus.attempts_left), 3);
    @(negedge clk);
    bus.confirm = 1'b0;
    repeat (4) @(negedge clk);

    // Three failures, each awaited, the last one locking out.
    bus.match = 1'b0;
    for (int t = 0; t < 3; t++) begin
      bus.confirm = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 12 && !seen; k++) begin
        @(posedge clk); #1;
        if (bus.error_pulse) seen = 1'b1;
      end
      chk("fail_seen", t, int'(seen), 1);
      chk("fail_left", t, int'(bus.attempts_left), 2 - t);
      chk("fail_locked", t, int'(bus.locked_out), (t == 2) ? 1 : 0);
      if (t < 2) begin
        @(negedge clk);
        bus.confirm = 1'b0;
        repeat (4) @(negedge clk);
      end
    end

    // Lockout duration, with a correct code tried during it.
    dur = 0; bad = 1'b0;
    while (bus.locked_out && dur < 100) begin
      dur++;
      if (dur == 2) begin
        @(negedge clk); bus.confirm = 1'b0;
      end else if (dur == 4) begin
        @(negedge clk); bus.match = 1'b1; bus.confirm = 1'b1; bus.cancel = 1'b1;
      end
      @(posedge clk); #1;
      if (bus.unlocked || bus.error_pulse) bad = 1'b1;
    end
    chk("lock_duration", 0, dur, LOCK_CYCLES);
    chk("lock_ignored", 0, int'(bad), 0);
    chk("lock_left", 0, int'(bus.attempts_left), 3);
    @(negedge clk);
    bus.confirm = 1'b0; bus.cancel = 1'b0; bus.match = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
